// File: rtl/datapath_pkg.sv
// Shared encodings for the multicycle MIPS datapath.
// Mux selects, mul/div opcodes, ALU ops and the mul/div FSM states.
package datapath_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_e;

  typedef enum logic [1:0] {
    WD_ALUOUT = 2'd0,
    WD_MDR    = 2'd1,
    WD_HI     = 2'd2,
    WD_LO     = 2'd3
  } wdsel_e;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'd0,
    PCSRC_ALUOUT = 2'd1,
    PCSRC_JUMP   = 2'd2,
    PCSRC_A      = 2'd3
  } pcsrc_e;

  typedef enum logic [1:0] {
    SRCA_PC  = 2'd0,
    SRCA_A   = 2'd1,
    SRCA_B   = 2'd2,
    SRCA_ONE = 2'd3
  } srca_e;

  typedef enum logic [1:0] {
    SRCB_B      = 2'd0,
    SRCB_FOUR   = 2'd1,
    SRCB_IMM    = 2'd2,
    SRCB_BRANCH = 2'd3
  } srcb_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2
  } md_state_e;

  localparam logic [4:0] ALU_AND  = 5'd0;
  localparam logic [4:0] ALU_OR   = 5'd1;
  localparam logic [4:0] ALU_ADD  = 5'd2;
  localparam logic [4:0] ALU_XOR  = 5'd3;
  localparam logic [4:0] ALU_NOR  = 5'd4;
  localparam logic [4:0] ALU_SUB  = 5'd6;
  localparam logic [4:0] ALU_SLT  = 5'd7;
  localparam logic [4:0] ALU_SLTU = 5'd8;

endpackage

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide unit with HI/LO result registers.
// One bit per cycle on magnitudes; the FIX state applies the signs.
module muldiv_iter
  import datapath_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  md_state_e r_state, w_next;

  logic [CW-1:0]    r_cnt;
  logic             r_div, r_negq, r_negr, r_divz, r_done;
  logic [WIDTH-1:0] r_acc, r_q, r_m, r_hi, r_lo;

  logic             w_sgn;
  logic [WIDTH-1:0] w_amag, w_bmag;
  logic [WIDTH:0]   w_add, w_sh;
  logic             w_ge;
  logic [WIDTH-1:0] w_dif;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0] w_hi_fix, w_lo_fix;

  assign w_sgn  = (op == MD_MULT) || (op == MD_DIV);
  assign w_amag = (w_sgn && a[WIDTH-1]) ? -a : a;
  assign w_bmag = (w_sgn && b[WIDTH-1]) ? -b : b;

  // r_acc is the product high half (mul) or partial remainder (div)
  assign w_add = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_m} : '0);
  assign w_sh  = {r_acc, r_q[WIDTH-1]};
  assign w_ge  = w_sh >= {1'b0, r_m};
  assign w_dif = w_sh[WIDTH-1:0] - r_m;

  assign w_prod = {r_acc, r_q};

  always_comb begin
    w_hi_fix = r_acc;
    w_lo_fix = r_q;
    if (!r_div) begin
      w_hi_fix = r_negq ? (-w_prod) >> WIDTH : w_prod[2*WIDTH-1:WIDTH];
      w_lo_fix = r_negq ? -r_q : r_q;
    end else begin
      w_hi_fix = r_negr ? -r_acc : r_acc;
      w_lo_fix = r_divz ? '1 : (r_negq ? -r_q : r_q);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= MD_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      MD_IDLE: if (start) w_next = MD_RUN;
      MD_RUN:  if (r_cnt == LAST) w_next = MD_FIX;
      MD_FIX:  w_next = MD_IDLE;
      default: w_next = MD_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != MD_IDLE);
    done = r_done;
    hi   = r_hi;
    lo   = r_lo;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_div  <= 1'b0;
      r_negq <= 1'b0;
      r_negr <= 1'b0;
      r_divz <= 1'b0;
      r_done <= 1'b0;
      r_acc  <= '0;
      r_q    <= '0;
      r_m    <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        MD_IDLE: if (start) begin
          r_acc  <= '0;
          r_q    <= w_amag;
          r_m    <= w_bmag;
          r_cnt  <= '0;
          r_div  <= op[1];
          r_negq <= w_sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
          r_negr <= w_sgn && a[WIDTH-1];
          r_divz <= (b == '0);
        end
        MD_RUN: begin
          r_cnt <= r_cnt + CW'(1);
          if (r_div) begin
            r_acc <= w_ge ? w_dif : w_sh[WIDTH-1:0];
            r_q   <= {r_q[WIDTH-2:0], w_ge};
          end else begin
            r_acc <= w_add[WIDTH:1];
            r_q   <= {w_add[0], r_q[WIDTH-1:1]};
          end
        end
        MD_FIX: begin
          r_hi   <= w_hi_fix;
          r_lo   <= w_lo_fix;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/datapath_md.sv
// Multicycle MIPS datapath: PC, IR, MDR, A/B, ALUOut, register file,
// ALU and an iterative mul/div unit, sequenced by an external controller.
module datapath_md
  import datapath_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter int               REGBITS  = 5,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr,
  input  logic [WIDTH-1:0] memdata,
  input  logic             irwrite,
  input  logic             pcen,
  input  logic             iord,
  input  logic             regwrite,
  input  logic             regdst,
  input  logic [1:0]       wdsel,
  input  logic             extop,
  input  logic [1:0]       alusrca,
  input  logic [1:0]       alusrcb,
  input  logic [1:0]       pcsource,
  input  logic [4:0]       alucont,
  input  logic             md_start,
  input  logic [1:0]       md_op,
  output logic [WIDTH-1:0] imem_adr,
  output logic [WIDTH-1:0] adr,
  output logic [WIDTH-1:0] writedata,
  output logic             zero,
  output logic             sign,
  output logic             overflow,
  output logic             md_busy,
  output logic             md_done
);

  localparam int NREG = 2 ** REGBITS;
  localparam int M    = WIDTH - 1;

  logic [WIDTH-1:0] r_pc, r_mdr, r_a, r_b, r_aluout;
  logic [31:0]      r_ir;
  logic [WIDTH-1:0] r_rf [NREG];

  logic [REGBITS-1:0] w_ra1, w_ra2, w_wa;
  logic [WIDTH-1:0]   w_rd1, w_rd2, w_wd;
  logic [WIDTH-1:0]   w_zext, w_sext, w_imm, w_brimm, w_jt;
  logic [WIDTH-1:0]   w_srca, w_srcb, w_res, w_pcnext;
  logic [WIDTH-1:0]   w_hi, w_lo;
  logic               w_ovf;
  logic               w_unused_ok;

  // opcode field is decoded by the controller, not here
  assign w_unused_ok = &{1'b0, r_ir[31:26]};

  assign w_ra1 = r_ir[21 +: REGBITS];
  assign w_ra2 = r_ir[16 +: REGBITS];
  assign w_wa  = regdst ? r_ir[11 +: REGBITS] : r_ir[16 +: REGBITS];
  assign w_rd1 = r_rf[w_ra1];
  assign w_rd2 = r_rf[w_ra2];

  generate
    if (WIDTH > 16) begin : g_imm
      assign w_zext = {{(WIDTH-16){1'b0}}, r_ir[15:0]};
      assign w_sext = {{(WIDTH-16){r_ir[15]}}, r_ir[15:0]};
    end else begin : g_imm_narrow
      assign w_zext = r_ir[WIDTH-1:0];
      assign w_sext = r_ir[WIDTH-1:0];
    end
    if (WIDTH > 28) begin : g_jt
      assign w_jt = {r_pc[WIDTH-1:28], r_ir[25:0], 2'b00};
    end else begin : g_jt_narrow
      logic [27:0] w_j28;
      assign w_j28 = {r_ir[25:0], 2'b00};
      assign w_jt  = w_j28[WIDTH-1:0];
    end
  endgenerate

  assign w_imm   = extop ? w_sext : w_zext;
  assign w_brimm = {w_sext[WIDTH-3:0], 2'b00};

  always_comb begin
    w_srca = r_pc;
    unique case (alusrca)
      SRCA_PC:  w_srca = r_pc;
      SRCA_A:   w_srca = r_a;
      SRCA_B:   w_srca = r_b;
      SRCA_ONE: w_srca = WIDTH'(1);
      default:  w_srca = r_pc;
    endcase
  end

  always_comb begin
    w_srcb = r_b;
    unique case (alusrcb)
      SRCB_B:      w_srcb = r_b;
      SRCB_FOUR:   w_srcb = WIDTH'(4);
      SRCB_IMM:    w_srcb = w_imm;
      SRCB_BRANCH: w_srcb = w_brimm;
      default:     w_srcb = r_b;
    endcase
  end

  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    case (alucont)
      ALU_AND: w_res = w_srca & w_srcb;
      ALU_OR:  w_res = w_srca | w_srcb;
      ALU_XOR: w_res = w_srca ^ w_srcb;
      ALU_NOR: w_res = ~(w_srca | w_srcb);
      ALU_ADD: begin
        w_res = w_srca + w_srcb;
        w_ovf = (w_srca[M] == w_srcb[M]) && (w_res[M] != w_srca[M]);
      end
      ALU_SUB: begin
        w_res = w_srca - w_srcb;
        w_ovf = (w_srca[M] != w_srcb[M]) && (w_res[M] != w_srca[M]);
      end
      ALU_SLT:  w_res = {{M{1'b0}}, $signed(w_srca) < $signed(w_srcb)};
      ALU_SLTU: w_res = {{M{1'b0}}, w_srca < w_srcb};
      default:  w_res = '0;
    endcase
  end

  assign zero     = (w_res == '0);
  assign sign     = w_res[M];
  assign overflow = w_ovf;

  always_comb begin
    w_pcnext = w_res;
    unique case (pcsource)
      PCSRC_ALU:    w_pcnext = w_res;
      PCSRC_ALUOUT: w_pcnext = r_aluout;
      PCSRC_JUMP:   w_pcnext = w_jt;
      PCSRC_A:      w_pcnext = r_a;
      default:      w_pcnext = w_res;
    endcase
  end

  always_comb begin
    w_wd = r_aluout;
    unique case (wdsel)
      WD_ALUOUT: w_wd = r_aluout;
      WD_MDR:    w_wd = r_mdr;
      WD_HI:     w_wd = w_hi;
      WD_LO:     w_wd = w_lo;
      default:   w_wd = r_aluout;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc     <= RESET_PC;
      r_ir     <= '0;
      r_mdr    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_aluout <= '0;
    end else begin
      if (irwrite) r_ir <= instr;
      if (pcen)    r_pc <= w_pcnext;
      r_mdr    <= memdata;
      r_a      <= w_rd1;
      r_b      <= w_rd2;
      r_aluout <= w_res;
    end
  end

  // register 0 reads as zero and ignores writes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
    end else if (regwrite && (w_wa != '0)) begin
      r_rf[w_wa] <= w_wd;
    end
  end

  muldiv_iter #(.WIDTH(WIDTH)) u_md (
    .clk   (clk),
    .reset (reset),
    .start (md_start),
    .op    (md_op),
    .a     (r_a),
    .b     (r_b),
    .busy  (md_busy),
    .done  (md_done),
    .hi    (w_hi),
    .lo    (w_lo)
  );

  assign imem_adr  = r_pc;
  assign adr       = iord ? r_aluout : r_pc;
  assign writedata = r_b;

endmodule
